gbn_tx_scheduler: RTL and testbench

- Go-back-N transmit scheduler for the TCP data phase.
- Decides which data sequence number the outgoing packet datapath builds next, tracks the send window against cumulative ACKs from the incoming-packet path, and rewinds to the oldest unacknowledged segment on timeout.
- Sits between the main connection FSM (start/abort, ISN, SNmax, window) and the outgoing packet builder. One sequence number = one packet.

---
 rtl/gbn_tx_scheduler_if.sv | 30 +++
 rtl/gbn_tx_scheduler.sv | 123 ++++++++++++
 tb/tb_gbn_tx_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/gbn_tx_scheduler_if.sv
// Control, request-handshake, ACK and status bundle between the connection FSM,
// the packet builder and the go-back-N transmit scheduler.
interface gbn_tx_scheduler_if;
  logic        start;
  logic        abort;
  logic [31:0] isn;
  logic [31:0] sn_max;
  logic [15:0] window;
  logic        ack_valid;
  logic [31:0] ack_num;
  logic        req_valid;
  logic [31:0] req_seq;
  logic        req_ready;
  logic [31:0] base_seq;
  logic [15:0] inflight;
  logic        busy;
  logic        done;
  logic [7:0]  retx_count;
  logic [3:0]  state_dbg;

  modport slave (
    input  start, abort, isn, sn_max, window, ack_valid, ack_num, req_ready,
    output req_valid, req_seq, base_seq, inflight, busy, done, retx_count, state_dbg
  );

  modport master (
    output start, abort, isn, sn_max, window, ack_valid, ack_num, req_ready,
    input  req_valid, req_seq, base_seq, inflight, busy, done, retx_count, state_dbg
  );
endinterface

// File: rtl/gbn_tx_scheduler.sv
// Go-back-N transmit scheduler: issues one sequence number per packet inside the
// send window, slides on cumulative ACKs and rewinds to base_seq on timeout.
module gbn_tx_scheduler #(
  parameter int TIMEOUT_CYCLES = 65000000,
  parameter int TIMER_W        = 27
) (
  input  logic               clk,
  input  logic               reset_n,
  gbn_tx_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [31:0]          base_q, base_d;
  logic [31:0]          next_q, next_d;
  logic [31:0]          snmax_q, snmax_d;
  logic [15:0]          win_q, win_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [7:0]           retx_q, retx_d;

  logic [31:0] out_diff;
  logic [31:0] ack_off;
  logic [15:0] eff_win;
  logic        req_valid;
  logic        accept;
  logic        pending;
  logic        ack_ok;
  logic        expired;

  // All window arithmetic is modular offsets from base_seq, so wrap is harmless.
  assign out_diff  = next_q - base_q;
  assign ack_off   = bus.ack_num - base_q;
  assign eff_win   = (win_q == 16'd0) ? 16'd1 : win_q;
  assign req_valid = (state_q == S_SEND) && (out_diff < {16'd0, eff_win}) && (next_q <= snmax_q);
  assign accept    = req_valid && bus.req_ready;
  assign pending   = req_valid && !bus.req_ready;
  assign ack_ok    = bus.ack_valid && (ack_off != 32'd0) && (ack_off <= out_diff);
  assign expired   = (timer_q == TIMER_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      next_q  <= '0;
      snmax_q <= '0;
      win_q   <= '0;
      timer_q <= '0;
      retx_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      next_q  <= next_d;
      snmax_q <= snmax_d;
      win_q   <= win_d;
      timer_q <= timer_d;
      retx_q  <= retx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    next_d  = next_q;
    snmax_d = snmax_q;
    win_d   = win_q;
    timer_d = timer_q;
    retx_d  = retx_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            base_d  = bus.isn;
            next_d  = bus.isn;
            snmax_d = bus.sn_max;
            win_d   = bus.window;
            timer_d = '0;
            retx_d  = '0;
            state_d = (bus.sn_max < bus.isn) ? S_DONE : S_SEND;
          end
        end
        S_SEND: begin
          if (accept) next_d = next_q + 32'd1;
          if (ack_ok) begin
            base_d  = bus.ack_num;
            timer_d = '0;
            if (bus.ack_num == snmax_q + 32'd1) state_d = S_DONE;
          end else if (expired) begin
            // A pending unaccepted request defers the rewind; the timer parks at its last value.
            if (!pending) begin
              next_d  = base_q;
              timer_d = '0;
              retx_d  = (retx_q == 8'hFF) ? retx_q : retx_q + 8'd1;
            end
          end else if (base_q != next_q) begin
            timer_d = timer_q + TIMER_W'(1);
          end else begin
            timer_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.req_valid  = req_valid;
  assign bus.req_seq    = next_q;
  assign bus.base_seq   = base_q;
  assign bus.inflight   = out_diff[15:0];
  assign bus.busy       = (state_q == S_SEND);
  assign bus.done       = (state_q == S_DONE);
  assign bus.retx_count = retx_q;
  assign bus.state_dbg  = {2'b00, state_q};

endmodule

// File: tb/tb_gbn_tx_scheduler.sv
// Directed bench for gbn_tx_scheduler with a short timeout; every expected
// value below is hand-derived from cycle counts of the scenario.
module tb_gbn_tx_scheduler;
  localparam int TO = 20;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  gbn_tx_scheduler_if bus ();

  gbn_tx_scheduler #(.TIMEOUT_CYCLES(TO), .TIMER_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_start(input logic [31:0] isn, input logic [31:0] snmax, input logic [15:0] win);
    bus.isn    = isn;
    bus.sn_max = snmax;
    bus.window = win;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic do_ack(input logic [31:0] num);
    bus.ack_valid = 1'b1;
    bus.ack_num   = num;
    tick();
    bus.ack_valid = 1'b0;
  endtask

  // Expect n back-to-back accepted requests starting at seq 'first' (req_ready must be 1).
  task automatic sends(input string tag, input logic [31:0] first, input int n);
    for (int k = 0; k < n; k++) begin
      check({tag, "_valid"}, {31'd0, bus.req_valid}, 32'd1);
      check({tag, "_seq"}, bus.req_seq, first + k);
      tick();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_valid"}, {31'd0, bus.req_valid}, 32'd0);
    check({tag, "_req_seq"}, bus.req_seq, 32'd0);
    check({tag, "_base"}, bus.base_seq, 32'd0);
    check({tag, "_inflight"}, {16'd0, bus.inflight}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_retx"}, {24'd0, bus.retx_count}, 32'd0);
    check({tag, "_state"}, {28'd0, bus.state_dbg}, 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.isn       = '0;
    bus.sn_max    = '0;
    bus.window    = '0;
    bus.ack_valid = 1'b0;
    bus.ack_num   = '0;
    bus.req_ready = 1'b0;
    ticks(2);
    check_all_zero("rst");
    reset_n = 1'b1;
    tick();

    // Basic window fill with isn=0, sn_max=10, window=3.
    bus.req_ready = 1'b1;
    do_start(32'd0, 32'd10, 16'd3);
    check("start_state", {28'd0, bus.state_dbg}, 32'd1);
    check("start_busy", {31'd0, bus.busy}, 32'd1);
    sends("fill", 32'd0, 3);
    check("full_valid", {31'd0, bus.req_valid}, 32'd0);
    check("full_inflight", {16'd0, bus.inflight}, 32'd3);

    do_ack(32'd2);
    check("ack2_base", bus.base_seq, 32'd2);
    sends("slide", 32'd3, 2);
    check("slide_valid", {31'd0, bus.req_valid}, 32'd0);
    check("slide_inflight", {16'd0, bus.inflight}, 32'd3);

    do_ack(32'd5);
    sends("burst5", 32'd5, 3);
    do_ack(32'd5);
    check("dup_base", bus.base_seq, 32'd5);
    check("dup_inflight", {16'd0, bus.inflight}, 32'd3);
    do_ack(32'd9);
    check("beyond_base", bus.base_seq, 32'd5);
    check("beyond_inflight", {16'd0, bus.inflight}, 32'd3);
    do_ack(32'd8);
    check("ack8_base", bus.base_seq, 32'd8);
    sends("burst8", 32'd8, 3);
    check("past_max_valid", {31'd0, bus.req_valid}, 32'd0);
    do_ack(32'd11);
    check("done_done", {31'd0, bus.done}, 32'd1);
    check("done_state", {28'd0, bus.state_dbg}, 32'd2);
    check("done_busy", {31'd0, bus.busy}, 32'd0);
    check("done_valid", {31'd0, bus.req_valid}, 32'd0);
    check("done_base", bus.base_seq, 32'd11);

    // Timeout: re-arm from DONE; first send at edge E1, rewind lands at E21.
    do_start(32'd0, 32'd10, 16'd3);
    check("rearm_retx", {24'd0, bus.retx_count}, 32'd0);
    sends("to_fill", 32'd0, 3);
    ticks(17);
    check("pre_to_retx", {24'd0, bus.retx_count}, 32'd0);
    check("pre_to_inflight", {16'd0, bus.inflight}, 32'd3);
    tick();
    check("to_retx", {24'd0, bus.retx_count}, 32'd1);
    check("to_inflight", {16'd0, bus.inflight}, 32'd0);
    check("to_valid", {31'd0, bus.req_valid}, 32'd1);
    check("to_seq", bus.req_seq, 32'd0);

    // Deferred expiry: seq 1 stalls past the timeout, rewind waits for acceptance.
    tick();
    bus.req_ready = 1'b0;
    ticks(24);
    check("stall_valid", {31'd0, bus.req_valid}, 32'd1);
    check("stall_seq", bus.req_seq, 32'd1);
    check("stall_retx", {24'd0, bus.retx_count}, 32'd1);
    bus.req_ready = 1'b1;
    tick();
    check("defer_retx", {24'd0, bus.retx_count}, 32'd2);
    check("defer_seq", bus.req_seq, 32'd0);
    check("defer_inflight", {16'd0, bus.inflight}, 32'd0);

    // ACK covering everything in flight arrives on the expiry cycle.
    sends("ae_fill", 32'd0, 3);
    bus.req_ready = 1'b0;
    ticks(17);
    check("ae_pre_inflight", {16'd0, bus.inflight}, 32'd3);
    do_ack(32'd3);
    check("ae_base", bus.base_seq, 32'd3);
    check("ae_inflight", {16'd0, bus.inflight}, 32'd0);
    check("ae_retx", {24'd0, bus.retx_count}, 32'd2);
    check("ae_seq", bus.req_seq, 32'd3);
    ticks(25);
    check("ae_idle_retx", {24'd0, bus.retx_count}, 32'd2);

    // Abort mid-SEND holds the counters.
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_state", {28'd0, bus.state_dbg}, 32'd0);
    check("abort_valid", {31'd0, bus.req_valid}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_base", bus.base_seq, 32'd3);
    check("abort_inflight", {16'd0, bus.inflight}, 32'd1);
    check("abort_retx", {24'd0, bus.retx_count}, 32'd2);

    // window=0 behaves as one packet in flight.
    do_start(32'd100, 32'd200, 16'd0);
    check("w0_valid", {31'd0, bus.req_valid}, 32'd1);
    check("w0_seq", bus.req_seq, 32'd100);
    bus.req_ready = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    check("w0_full_valid", {31'd0, bus.req_valid}, 32'd0);
    check("w0_inflight", {16'd0, bus.inflight}, 32'd1);
    do_ack(32'd101);
    check("w0_ack_base", bus.base_seq, 32'd101);
    check("w0_ack_seq", bus.req_seq, 32'd101);
    check("w0_ack_valid", {31'd0, bus.req_valid}, 32'd1);

    // Asynchronous reset between clock edges.
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("arst");
    tick();
    reset_n = 1'b1;
    tick();

    // sn_max < isn goes straight to DONE.
    do_start(32'd50, 32'd10, 16'd4);
    check("empty_state", {28'd0, bus.state_dbg}, 32'd2);
    check("empty_done", {31'd0, bus.done}, 32'd1);
    check("empty_valid", {31'd0, bus.req_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
